// File: rtl/brisc_rob.sv
// -----------------------------------------------------------------------------
// brisc_rob : reorder buffer for the brisc pipeline.
//
// Hands out in-order tickets at decode, collects out-of-order completions from
// NUM_REQS writeback channels, and retires completed entries strictly in
// program order (one per cycle) toward the register file and store path.
// An entry retiring with a non-zero exception code flushes the whole buffer.
//
// Ports
//   i_clk, i_rst            : clock (rising edge), async active-high reset
//   i_alloc_valid           : decode requests a ticket
//   o_alloc_ready           : allocation accepted this cycle
//   o_alloc_ticket          : ticket granted (tail index)
//   i_req_valid  [R]        : per-channel completion valid
//   i_req_ticket [R*T]      : completing ticket, channel 0 in the LSBs
//   i_req_result [R*XLEN]   : result value
//   i_req_dest   [R*REG_LEN]: destination register
//   i_req_reg_rw / i_req_mem_rw [R] : register / memory write intent
//   i_req_xcpt   [R*2]      : exception code (0 = none)
//   o_commit_*              : fields of the entry retiring this cycle
//   o_flush                 : retiring entry carries an exception
//   o_count                 : occupied entries
// -----------------------------------------------------------------------------
module brisc_rob #(
  parameter  int NUM_ENTRIES = 32,
  parameter  int NUM_REQS    = 2,
  parameter  int XLEN        = 32,
  parameter  int REG_LEN     = 5,
  localparam int TICKET_LEN  = $clog2(NUM_ENTRIES)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_alloc_valid,
  output logic                           o_alloc_ready,
  output logic [TICKET_LEN-1:0]          o_alloc_ticket,
  input  logic [NUM_REQS-1:0]            i_req_valid,
  input  logic [NUM_REQS*TICKET_LEN-1:0] i_req_ticket,
  input  logic [NUM_REQS*XLEN-1:0]       i_req_result,
  input  logic [NUM_REQS*REG_LEN-1:0]    i_req_dest,
  input  logic [NUM_REQS-1:0]            i_req_reg_rw,
  input  logic [NUM_REQS-1:0]            i_req_mem_rw,
  input  logic [NUM_REQS*2-1:0]          i_req_xcpt,
  output logic                           o_commit_valid,
  output logic [TICKET_LEN-1:0]          o_commit_ticket,
  output logic [XLEN-1:0]                o_commit_result,
  output logic [REG_LEN-1:0]             o_commit_dest,
  output logic [1:0]                     o_commit_xcpt,
  output logic                           o_commit_reg_rw,
  output logic                           o_commit_mem_rw,
  output logic                           o_flush,
  output logic [TICKET_LEN:0]            o_count
);

  localparam logic [TICKET_LEN:0] PTR_ONE    = {{TICKET_LEN{1'b0}}, 1'b1};
  localparam logic [TICKET_LEN:0] FULL_COUNT = {1'b1, {TICKET_LEN{1'b0}}};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TICKET_LEN:0]    r_head;
  logic [TICKET_LEN:0]    r_tail;
  logic [NUM_ENTRIES-1:0] r_busy;
  logic [NUM_ENTRIES-1:0] r_done;
  logic [XLEN-1:0]        r_result [NUM_ENTRIES];
  logic [REG_LEN-1:0]     r_dest   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_reg_rw;
  logic [NUM_ENTRIES-1:0] r_mem_rw;
  logic [1:0]             r_xcpt   [NUM_ENTRIES];

  logic [TICKET_LEN:0]    w_count;
  logic [TICKET_LEN-1:0]  w_head_idx;
  logic [TICKET_LEN-1:0]  w_tail_idx;
  logic                   w_full;
  logic                   w_commit;
  logic                   w_flush;
  logic                   w_alloc;

  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[TICKET_LEN-1:0];
  assign w_tail_idx = r_tail[TICKET_LEN-1:0];
  assign w_full     = (w_count == FULL_COUNT);
  // Commit depends only on registered state: no completion-to-commit path.
  assign w_commit   = r_busy[w_head_idx] & r_done[w_head_idx];
  assign w_flush    = w_commit & (r_xcpt[w_head_idx] != 2'b00);
  assign w_alloc    = i_alloc_valid & o_alloc_ready;

  assign o_alloc_ready  = ~w_full & ~w_flush;
  assign o_alloc_ticket = w_tail_idx;
  assign o_count        = w_count;
  assign o_flush        = w_flush;

  // Commit port: head entry fields while retiring, zeros otherwise.
  always_comb begin
    if (w_commit) begin
      o_commit_valid  = 1'b1;
      o_commit_ticket = w_head_idx;
      o_commit_result = r_result[w_head_idx];
      o_commit_dest   = r_dest[w_head_idx];
      o_commit_xcpt   = r_xcpt[w_head_idx];
      // Write enables are suppressed for an excepting instruction.
      o_commit_reg_rw = r_reg_rw[w_head_idx] & ~w_flush;
      o_commit_mem_rw = r_mem_rw[w_head_idx] & ~w_flush;
    end else begin
      o_commit_valid  = 1'b0;
      o_commit_ticket = '0;
      o_commit_result = '0;
      o_commit_dest   = '0;
      o_commit_xcpt   = 2'b00;
      o_commit_reg_rw = 1'b0;
      o_commit_mem_rw = 1'b0;
    end
  end

  // Pointer, status and payload state: reset, flush, completion, commit, alloc.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_busy   <= '0;
      r_done   <= '0;
      r_reg_rw <= '0;
      r_mem_rw <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        r_result[e] <= '0;
        r_dest[e]   <= '0;
        r_xcpt[e]   <= 2'b00;
      end
    end else if (w_flush) begin
      // Same-cycle completions and allocations are discarded with the flush.
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      // Highest channel first so the lowest-index channel's write lands last
      // and wins a same-ticket collision.
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (i_req_valid[i] && r_busy[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]]) begin
          r_result[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]] <= i_req_result[i*XLEN +: XLEN];
          r_dest[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]]   <= i_req_dest[i*REG_LEN +: REG_LEN];
          r_reg_rw[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]] <= i_req_reg_rw[i];
          r_mem_rw[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]] <= i_req_mem_rw[i];
          r_xcpt[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]]   <= i_req_xcpt[i*2 +: 2];
          r_done[i_req_ticket[i*TICKET_LEN +: TICKET_LEN]]   <= 1'b1;
        end
      end
      if (w_commit) begin
        r_busy[w_head_idx] <= 1'b0;
        r_head             <= r_head + PTR_ONE;
      end
      // The tail entry is never busy when not full, so this cannot collide
      // with a completion or with the commit above.
      if (w_alloc) begin
        r_busy[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx] <= 1'b0;
        r_tail             <= r_tail + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_brisc_rob.sv
// -----------------------------------------------------------------------------
// tb_brisc_rob : self-checking bench for brisc_rob (default parameters).
// A queue-of-entries program-order model is checked every cycle; directed
// tables and sequences cover ordering, collisions, flush, wrap and reset.
// -----------------------------------------------------------------------------
module tb_brisc_rob;

  localparam int N  = 32;
  localparam int R  = 2;
  localparam int XL = 32;
  localparam int RL = 5;
  localparam int TL = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [TL-1:0]   alloc_ticket;
  logic [R-1:0]    req_valid;
  logic [R*TL-1:0] req_ticket;
  logic [R*XL-1:0] req_result;
  logic [R*RL-1:0] req_dest;
  logic [R-1:0]    req_reg_rw;
  logic [R-1:0]    req_mem_rw;
  logic [R*2-1:0]  req_xcpt;
  logic            commit_valid;
  logic [TL-1:0]   commit_ticket;
  logic [XL-1:0]   commit_result;
  logic [RL-1:0]   commit_dest;
  logic [1:0]      commit_xcpt;
  logic            commit_reg_rw;
  logic            commit_mem_rw;
  logic            flush;
  logic [TL:0]     count;

  always #5 clk = ~clk;

  brisc_rob #(.NUM_ENTRIES(N), .NUM_REQS(R), .XLEN(XL), .REG_LEN(RL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready), .o_alloc_ticket(alloc_ticket),
    .i_req_valid(req_valid), .i_req_ticket(req_ticket), .i_req_result(req_result),
    .i_req_dest(req_dest), .i_req_reg_rw(req_reg_rw), .i_req_mem_rw(req_mem_rw),
    .i_req_xcpt(req_xcpt),
    .o_commit_valid(commit_valid), .o_commit_ticket(commit_ticket),
    .o_commit_result(commit_result), .o_commit_dest(commit_dest),
    .o_commit_xcpt(commit_xcpt), .o_commit_reg_rw(commit_reg_rw),
    .o_commit_mem_rw(commit_mem_rw), .o_flush(flush), .o_count(count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: entries in program order ----------------
  typedef struct {
    int         tk;
    bit         done;
    logic [31:0] res;
    logic [4:0] dest;
    bit         rr;
    bit         mr;
    logic [1:0] x;
  } ent_t;

  ent_t mq[$];
  int   m_tail;

  function automatic bit m_cv();
    return (mq.size() > 0) && mq[0].done;
  endfunction

  function automatic bit m_flush();
    return m_cv() && (mq[0].x != 2'b00);
  endfunction

  function automatic bit m_ready();
    return (mq.size() < N) && !m_flush();
  endfunction

  task automatic m_reset();
    mq.delete();
    m_tail = 0;
  endtask

  task automatic check_model();
    chk("alloc_ready", alloc_ready, m_ready());
    chk("alloc_ticket", alloc_ticket, m_tail);
    chk("count", count, mq.size());
    chk("commit_valid", commit_valid, m_cv());
    chk("flush", flush, m_flush());
    if (m_cv()) begin
      chk("commit_ticket", commit_ticket, mq[0].tk);
      chk("commit_result", commit_result, mq[0].res);
      chk("commit_dest", commit_dest, mq[0].dest);
      chk("commit_xcpt", commit_xcpt, mq[0].x);
      chk("commit_reg_rw", commit_reg_rw, mq[0].rr && mq[0].x == 2'b00);
      chk("commit_mem_rw", commit_mem_rw, mq[0].mr && mq[0].x == 2'b00);
    end
  endtask

  task automatic step_model();
    bit   cv  = m_cv();
    bit   rdy = m_ready();
    bit   seen [N];
    int   tk;
    ent_t e;
    if (m_flush()) begin
      m_reset();
      return;
    end
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    for (int ch = 0; ch < R; ch++) begin
      if (req_valid[ch]) begin
        tk = int'(req_ticket[ch*TL +: TL]);
        if (!seen[tk]) begin
          seen[tk] = 1'b1;
          for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].tk == tk) begin
              mq[j].done = 1'b1;
              mq[j].res  = req_result[ch*XL +: XL];
              mq[j].dest = req_dest[ch*RL +: RL];
              mq[j].rr   = req_reg_rw[ch];
              mq[j].mr   = req_mem_rw[ch];
              mq[j].x    = req_xcpt[ch*2 +: 2];
            end
          end
        end
      end
    end
    if (cv) void'(mq.pop_front());
    if (alloc_valid && rdy) begin
      e.tk = m_tail; e.done = 1'b0; e.res = '0; e.dest = '0;
      e.rr = 1'b0; e.mr = 1'b0; e.x = 2'b00;
      mq.push_back(e);
      m_tail = (m_tail + 1) % N;
    end
  endtask

  // One clock: check at the falling edge, advance model, step past rising edge.
  task automatic tick();
    @(negedge clk);
    check_model();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    alloc_valid = 1'b0;
    req_valid   = '0;
    req_ticket  = '0;
    req_result  = '0;
    req_dest    = '0;
    req_reg_rw  = '0;
    req_mem_rw  = '0;
    req_xcpt    = '0;
  endtask

  task automatic comp(input int ch, input int tk, input logic [31:0] res, input logic [1:0] x);
    logic [TL-1:0] t5;
    t5 = tk[TL-1:0];
    req_valid[ch]             = 1'b1;
    req_ticket[ch*TL +: TL]   = t5;
    req_result[ch*XL +: XL]   = res;
    req_dest[ch*RL +: RL]     = t5 ^ 5'h15;
    req_reg_rw[ch]            = 1'b1;
    req_mem_rw[ch]            = t5[0];
    req_xcpt[ch*2 +: 2]       = x;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          av;
    bit [1:0]    rv;
    int          t0;
    int          t1;
    logic [31:0] r0;
    logic [31:0] r1;
    bit          e_cv;
    int          e_ct;
    logic [31:0] e_res;
    int          e_cnt;
    int          e_at;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncommit;
    int guard;
    int tk;

    // out-of-order completion then dual completion / same-ticket collision
    tbl[0]  = '{1'b1, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  0, 0};
    tbl[1]  = '{1'b1, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  1, 1};
    tbl[2]  = '{1'b1, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  2, 2};
    tbl[3]  = '{1'b0, 2'b01, 2, 0, 32'hC,  32'h0,  1'b0, 0, 32'h0,  3, 3};
    tbl[4]  = '{1'b0, 2'b01, 1, 0, 32'hB,  32'h0,  1'b0, 0, 32'h0,  3, 3};
    tbl[5]  = '{1'b0, 2'b10, 0, 0, 32'h0,  32'hA,  1'b0, 0, 32'h0,  3, 3};
    tbl[6]  = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b1, 0, 32'hA,  3, 3};
    tbl[7]  = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b1, 1, 32'hB,  2, 3};
    tbl[8]  = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b1, 2, 32'hC,  1, 3};
    tbl[9]  = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  0, 3};
    tbl[10] = '{1'b1, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  0, 3};
    tbl[11] = '{1'b1, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  1, 4};
    tbl[12] = '{1'b1, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  2, 5};
    tbl[13] = '{1'b0, 2'b11, 3, 4, 32'h33, 32'h44, 1'b0, 0, 32'h0,  3, 6};
    tbl[14] = '{1'b0, 2'b11, 5, 5, 32'h55, 32'h99, 1'b1, 3, 32'h33, 3, 6};
    tbl[15] = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b1, 4, 32'h44, 2, 6};
    tbl[16] = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b1, 5, 32'h55, 1, 6};
    tbl[17] = '{1'b0, 2'b00, 0, 0, 32'h0,  32'h0,  1'b0, 0, 32'h0,  0, 6};

    // ---- reset state ----
    clr_in();
    rst = 1'b1;
    m_reset();
    #12;
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_alloc_ticket", alloc_ticket, 0);
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_commit_result", commit_result, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---- fill and drain ----
    for (int i = 0; i < N; i++) begin
      alloc_valid = 1'b1;
      #1;
      chk("fill_ticket", alloc_ticket, i);
      tick();
    end
    clr_in();
    #1;
    chk("full_count", count, 32);
    chk("full_alloc_ready", alloc_ready, 1'b0);
    ncommit = 0;
    for (int k = 0; k < N / 2; k++) begin
      comp(0, 2 * k, 32'h100 + 2 * k, 2'b00);
      comp(1, 2 * k + 1, 32'h101 + 2 * k, 2'b00);
      #1;
      if (commit_valid) begin
        chk("drain_order", commit_ticket, ncommit % N);
        ncommit++;
      end
      tick();
      clr_in();
    end
    guard = 0;
    while (count != 0 && guard < 64) begin
      #1;
      if (commit_valid) begin
        chk("drain_order", commit_ticket, ncommit % N);
        ncommit++;
      end
      tick();
      guard++;
    end
    chk("drain_count", count, 0);
    chk("drain_commits", ncommit, 32);

    // ---- table: out-of-order, dual completion, collision ----
    for (int k = 0; k < 18; k++) begin
      clr_in();
      alloc_valid = tbl[k].av;
      if (tbl[k].rv[0]) comp(0, tbl[k].t0, tbl[k].r0, 2'b00);
      if (tbl[k].rv[1]) comp(1, tbl[k].t1, tbl[k].r1, 2'b00);
      #1;
      chk("tbl_commit_valid", commit_valid, tbl[k].e_cv);
      if (tbl[k].e_cv) begin
        chk("tbl_commit_ticket", commit_ticket, tbl[k].e_ct);
        chk("tbl_commit_result", commit_result, tbl[k].e_res);
      end
      chk("tbl_count", count, tbl[k].e_cnt);
      chk("tbl_alloc_ticket", alloc_ticket, tbl[k].e_at);
      tick();
    end
    clr_in();

    // ---- reset mid-stream with 10 entries busy ----
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
    clr_in();
    comp(0, 6, 32'h66, 2'b00);
    tick();
    clr_in();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_alloc_ready", alloc_ready, 1'b1);
    chk("mrst_alloc_ticket", alloc_ticket, 0);
    chk("mrst_commit_valid", commit_valid, 1'b0);
    chk("mrst_commit_ticket", commit_ticket, 0);
    chk("mrst_flush", flush, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;

    // ---- exception flush ----
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
    clr_in();
    comp(0, 1, 32'hDEAD, 2'd2);
    comp(1, 0, 32'hA0, 2'b00);
    tick();
    clr_in();
    #1;
    chk("xc_c0_valid", commit_valid, 1'b1);
    chk("xc_c0_ticket", commit_ticket, 0);
    chk("xc_c0_flush", flush, 1'b0);
    chk("xc_c0_reg_rw", commit_reg_rw, 1'b1);
    tick();
    alloc_valid = 1'b1;
    comp(0, 2, 32'h22, 2'b00);
    #1;
    chk("xc_c1_valid", commit_valid, 1'b1);
    chk("xc_c1_ticket", commit_ticket, 1);
    chk("xc_c1_flush", flush, 1'b1);
    chk("xc_c1_reg_rw", commit_reg_rw, 1'b0);
    chk("xc_c1_mem_rw", commit_mem_rw, 1'b0);
    chk("xc_c1_xcpt", commit_xcpt, 2);
    chk("xc_c1_alloc_ready", alloc_ready, 1'b0);
    tick();
    clr_in();
    #1;
    chk("xc_after_count", count, 0);
    chk("xc_after_ticket", alloc_ticket, 0);
    chk("xc_after_ready", alloc_ready, 1'b1);
    chk("xc_after_flush", flush, 1'b0);
    tick();

    // ---- wrap at occupancy 31 ----
    for (int i = 0; i < N - 1; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
    clr_in();
    comp(0, 0, 32'h5000, 2'b00);
    tick();
    clr_in();
    for (int k = 0; k < 100; k++) begin
      alloc_valid = 1'b1;
      comp(0, (k + 1) % N, 32'h6000 + k, 2'b00);
      #1;
      chk("wrap_count", count, 31);
      chk("wrap_commit_valid", commit_valid, 1'b1);
      chk("wrap_commit_ticket", commit_ticket, k % N);
      chk("wrap_alloc_ticket", alloc_ticket, (31 + k) % N);
      tick();
      clr_in();
    end

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      clr_in();
      alloc_valid = ($urandom_range(0, 99) < 60);
      for (int ch = 0; ch < R; ch++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            tk = mq[$urandom_range(0, mq.size() - 1)].tk;
          else
            tk = $urandom_range(0, N - 1);
          comp(ch, tk, $urandom(),
               ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
      end
      tick();
    end
    clr_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brisc_rob.md
# brisc_rob

Parametrised reorder buffer for the brisc pipeline. Issues in-order tickets at decode, accepts out-of-order completions from `NUM_REQS` writeback channels, and retires completed entries strictly in program order, one per cycle, toward the register file and store path. Generalises the fixed 32-entry, 2-request ROB with configurable depth, channel count and data widths, and adds precise exception flush.

## Interface
- `NUM_ENTRIES`, 32: ROB depth. Must be a power of two, ≥2.
- `NUM_REQS`, 2: number of writeback (completion) channels.
- `XLEN`, 32: result width.
- `REG_LEN`, 5: destination register index width.
- `TICKET_LEN`, $clog2(NUM_ENTRIES): derived, not overridable.

Ports:
- `clk` in 1: clock. Everything is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `alloc_valid` in 1: decode requests a ticket.
- `alloc_ready` out 1: allocation accepted this cycle.
- `alloc_ticket` out TICKET_LEN: ticket granted (current tail index).
- `req_valid` in NUM_REQS: completion valid per channel.
- `req_ticket` in NUM_REQS*TICKET_LEN: completing ticket, packed with channel 0 in the LSBs.
- `req_result` in NUM_REQS*XLEN: result value.
- `req_dest` in NUM_REQS*REG_LEN: destination register.
- `req_reg_rw`, `req_mem_rw` in NUM_REQS each: register-write and memory-write intent.
- `req_xcpt` in NUM_REQS*2: exception code (0 NO_XCPT, 1 MEM_UNALIGNED, 2 UNDEF_INSTR, 3 ADDR_INVALID).
- `commit_valid` out 1: head entry retires this cycle.
- `commit_ticket` out TICKET_LEN, `commit_result` out XLEN, `commit_dest` out REG_LEN, `commit_xcpt` out 2: fields of the retiring entry.
- `commit_reg_rw`, `commit_mem_rw` out 1 each: write enables, gated to 0 when `commit_xcpt` ≠ 0.
- `flush` out 1: the retiring entry carries an exception.
- `count` out TICKET_LEN+1: occupied entries.

## Operation
- State:
  - `head` and `tail` pointers, each TICKET_LEN+1 bits (wrap bit + index).
  - Per entry: `busy` (allocated), `done` (completed), result, dest, reg_rw, mem_rw, xcpt.
- Occupancy:
  - `count` = `tail` − `head` (mod 2^(TICKET_LEN+1)).
  - full when `count` == NUM_ENTRIES; empty when `count` == 0.
- Allocation:
  - `alloc_ready` = !full && !flush. This is combinational and does not depend on a same-cycle commit.
  - When `alloc_valid` && `alloc_ready`: set `busy` at the tail index, clear `done`, increment `tail`.
  - `alloc_ticket` is always the tail index.
- Completion:
  - Per channel, when `req_valid[i]` && `busy[req_ticket[i]]`: write the fields and set `done`.
  - A completion to a non-busy ticket is ignored.
  - Two channels naming the same ticket in one cycle: the lowest channel index wins.
- Commit:
  - `commit_valid` = `busy[head]` && `done[head]`, combinational from registered state.
  - On commit: clear `busy[head]` and increment `head`.
- Flush:
  - `flush` = `commit_valid` && `commit_xcpt` ≠ 0.
  - In the flush cycle, the entry is reported on the commit port with write enables forced to 0.
  - On that edge: clear every `busy`/`done`, set `head` = `tail` = 0, and drop any same-cycle completions and allocations.
- Simultaneous alloc and commit while non-full: `count` is unchanged.
- Wrap-around: the index wraps modulo NUM_ENTRIES; the wrap bit distinguishes full from empty.

## Timing
- Reset values:
  - `alloc_ready` = 1; `alloc_ticket` = 0; `count` = 0.
  - All `commit_*` outputs = 0; `flush` = 0.
  - All `busy`/`done` bits = 0; `head` = `tail` = 0.
- Reset is honoured mid-operation: the next cycle after deassertion is identical to post-reset.
- Allocation: ticket valid in the same cycle as the handshake; the entry is busy from the next edge.
- Completion to commit: a completion at cycle N can retire at cycle N+1 at the earliest (`done` is registered). There is no combinational completion-to-commit path.
- Throughput: 1 alloc, NUM_REQS completions and 1 commit per cycle.
- Flush: asserted for exactly one cycle. At the next cycle `count` = 0 and `alloc_ready` = 1.

## Test plan
- Fill and drain:
  - Allocate 32 tickets back-to-back → tickets 0..31, `count` = 32, `alloc_ready` = 0.
  - Complete all tickets → 32 commits on consecutive cycles in order 0..31.
  - End state: `count` = 0.
- Out-of-order completion:
  - Allocate 0,1,2. Complete 2 (result 0xC), then 1 (0xB), then 0 (0xA).
  - Commits 0,1,2 occur only after ticket 0 completes, on consecutive cycles, results 0xA, 0xB, 0xC.
- Dual completion, same cycle:
  - Channels 0 and 1 complete tickets 3 and 4 together, with 3 at the head.
  - Both retire on the next two cycles.
  - Same-ticket collision: channel 0 data retained.
- Exception flush:
  - Allocate 0..5. Complete 1 with `req_xcpt` = 2, and 0 normally.
  - Commit 0 normally.
  - Next cycle: ticket 1 commits with `flush` = 1 and `commit_reg_rw` = 0.
  - Following cycle: `count` = 0 and `alloc_ticket` = 0.
- Wrap and full boundary:
  - Keep occupancy at 31 while allocating and committing every cycle for 100 cycles.
  - Tickets wrap 31→0, `count` stays 31, and order is preserved.
- Reset mid-stream: assert `rst` with 10 entries busy → all outputs return to their reset values immediately (asynchronously).
